// File: rtl/vga_timing_pkg.sv
// Shared constants and types for the 800x600 VGA raster path.
// Defaults describe VESA 800x600@72 Hz with positive sync polarity.
package vga_timing_pkg;

    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int DEF_CLK_DIV   = 2;

    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FP      = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BP      = 64;
    localparam int DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;

    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FP      = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BP      = 23;
    localparam int DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HSYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HSYNC_END   = DEF_HSYNC_START + DEF_H_SYNC;
    localparam int DEF_VSYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VSYNC_END   = DEF_VSYNC_START + DEF_V_SYNC;

    localparam bit DEF_SYNC_POL = 1'b1;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } raster_flags_t;

    // Half-open window test [lo, hi) on unsigned coordinates.
    function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Generic clock-enable divider: strobes 'advance' on every CLK_DIV-th clock edge.
// The strobe is high during the cycle whose closing edge is the advance edge.
module pixel_tick_div #(
    parameter int CLK_DIV = 2
) (
    input  logic CLK_100MHz,
    input  logic RESET,
    output logic advance
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;

    // With CLK_DIV=1 the counter is pinned at 0 and every edge advances.
    assign advance = (div_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (advance) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, blank/sync decode and frame pulses.
// Flags are decoded from next-state coordinates so they register alongside them.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit SYNC_POL  = DEF_SYNC_POL
) (
    input  logic               CLK_100MHz,
    input  logic               RESET,
    output logic [COORD_W-1:0] CurrentX,
    output logic [COORD_W-1:0] CurrentY,
    output logic               HBlank,
    output logic               VBlank,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic               PixelTick,
    output logic               FrameStart,
    output logic [7:0]         FrameCount
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam coord_t X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t X_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t Y_VIS    = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);

    localparam raster_flags_t FLAGS_RESET = '{
        hblank: 1'b0,
        vblank: 1'b0,
        hsync:  ~SYNC_POL,
        vsync:  ~SYNC_POL
    };

    logic          advance;
    coord_t        x_next;
    coord_t        y_next;
    logic          frame_wrap;
    raster_flags_t flags_next;
    raster_flags_t flags;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_div (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (RESET),
        .advance    (advance)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        x_next     = CurrentX;
        y_next     = CurrentY;
        frame_wrap = 1'b0;
        if (advance) begin
            if (CurrentX == X_LAST) begin
                x_next = '0;
                if (CurrentY == Y_LAST) begin
                    y_next     = '0;
                    frame_wrap = 1'b1;
                end else begin
                    y_next = CurrentY + 1'b1;
                end
            end else begin
                x_next = CurrentX + 1'b1;
            end
        end
    end

    // y_next only moves on the X wrap, which keeps VSYNC line-aligned.
    always_comb begin
        flags_next        = FLAGS_RESET;
        flags_next.hblank = (x_next >= X_VIS);
        flags_next.vblank = (y_next >= Y_VIS);
        flags_next.hsync  = SYNC_POL ? in_window(x_next, HS_START, HS_END)
                                     : ~in_window(x_next, HS_START, HS_END);
        flags_next.vsync  = SYNC_POL ? in_window(y_next, VS_START, VS_END)
                                     : ~in_window(y_next, VS_START, VS_END);
    end

    always_ff @(posedge CLK_100MHz or posedge RESET) begin
        if (RESET) begin
            CurrentX   <= '0;
            CurrentY   <= '0;
            flags      <= FLAGS_RESET;
            PixelTick  <= 1'b0;
            FrameStart <= 1'b0;
            FrameCount <= '0;
        end else begin
            CurrentX   <= x_next;
            CurrentY   <= y_next;
            flags      <= flags_next;
            PixelTick  <= advance;
            FrameStart <= frame_wrap;
            if (frame_wrap) begin
                FrameCount <= FrameCount + 1'b1;
            end
        end
    end

    assign HBlank = flags.hblank;
    assign VBlank = flags.vblank;
    assign HSYNC  = flags.hsync;
    assign VSYNC  = flags.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, a CLK_DIV=1 active-low-sync
// variant, and a tiny 8x4 raster used for frame-level and FrameCount-wrap checks.
module tb_vga_timing_gen;

    logic CLK_100MHz = 1'b0;
    logic RESET      = 1'b1;

    always #5 CLK_100MHz = ~CLK_100MHz;

    // u_def: default parameters
    logic [10:0] d_x, d_y;
    logic        d_hblank, d_vblank, d_hsync, d_vsync, d_tick, d_fs;
    logic [7:0]  d_fc;
    // u_fast: CLK_DIV=1, active-low syncs
    logic [10:0] f_x, f_y;
    logic        f_hblank, f_vblank, f_hsync, f_vsync, f_tick, f_fs;
    logic [7:0]  f_fc;
    // u_small: H_TOTAL=8 (vis 4, fp 1, sync 2, bp 1), V_TOTAL=4 (vis 1, fp 1, sync 1, bp 1)
    logic [10:0] s_x, s_y;
    logic        s_hblank, s_vblank, s_hsync, s_vsync, s_tick, s_fs;
    logic [7:0]  s_fc;

    vga_timing_gen u_def (
        .CLK_100MHz (CLK_100MHz), .RESET (RESET),
        .CurrentX (d_x), .CurrentY (d_y), .HBlank (d_hblank), .VBlank (d_vblank),
        .HSYNC (d_hsync), .VSYNC (d_vsync), .PixelTick (d_tick),
        .FrameStart (d_fs), .FrameCount (d_fc)
    );

    vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b0)) u_fast (
        .CLK_100MHz (CLK_100MHz), .RESET (RESET),
        .CurrentX (f_x), .CurrentY (f_y), .HBlank (f_hblank), .VBlank (f_vblank),
        .HSYNC (f_hsync), .VSYNC (f_vsync), .PixelTick (f_tick),
        .FrameStart (f_fs), .FrameCount (f_fc)
    );

    vga_timing_gen #(
        .CLK_DIV(2), .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(1), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_small (
        .CLK_100MHz (CLK_100MHz), .RESET (RESET),
        .CurrentX (s_x), .CurrentY (s_y), .HBlank (s_hblank), .VBlank (s_vblank),
        .HSYNC (s_hsync), .VSYNC (s_vsync), .PixelTick (s_tick),
        .FrameStart (s_fs), .FrameCount (s_fc)
    );

    int checks = 0;
    int errors = 0;
    int edges  = 0;
    int n      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the negedge following rising edge 'target' since the last release.
    task automatic goto_edge(input int target);
        while (edges < target) begin
            @(negedge CLK_100MHz);
            edges++;
        end
    endtask

    initial begin
        // Reset held
        repeat (3) @(negedge CLK_100MHz);
        check("rst_d_x",      d_x, 0);
        check("rst_d_y",      d_y, 0);
        check("rst_d_hblank", d_hblank, 0);
        check("rst_d_vblank", d_vblank, 0);
        check("rst_d_hsync",  d_hsync, 0);
        check("rst_d_vsync",  d_vsync, 0);
        check("rst_d_tick",   d_tick, 0);
        check("rst_d_fs",     d_fs, 0);
        check("rst_d_fc",     d_fc, 0);
        check("rst_f_hsync",  f_hsync, 1);
        check("rst_f_vsync",  f_vsync, 1);
        check("rst_f_tick",   f_tick, 0);

        RESET = 1'b0;
        edges = 0;

        goto_edge(1);
        check("e1_d_x",    d_x, 0);
        check("e1_d_tick", d_tick, 0);
        check("e1_f_x",    f_x, 1);
        check("e1_f_tick", f_tick, 1);
        check("e1_s_fs",   s_fs, 0);
        goto_edge(2);
        check("e2_d_x",    d_x, 1);
        check("e2_d_tick", d_tick, 1);
        check("e2_f_x",    f_x, 2);
        check("e2_f_tick", f_tick, 1);
        goto_edge(3);
        check("e3_d_x",    d_x, 1);
        check("e3_d_tick", d_tick, 0);

        // Small raster: horizontal decode
        goto_edge(9);
        check("s_x4",        s_x, 4);
        check("s_x4_hblank", s_hblank, 1);
        check("s_x4_hsync",  s_hsync, 0);
        goto_edge(10);
        check("s_x5",        s_x, 5);
        check("s_x5_hsync",  s_hsync, 1);
        goto_edge(14);
        check("s_x7",        s_x, 7);
        check("s_x7_hsync",  s_hsync, 0);
        goto_edge(16);
        check("s_l1_x",      s_x, 0);
        check("s_l1_y",      s_y, 1);
        check("s_l1_vblank", s_vblank, 1);
        check("s_l1_hblank", s_hblank, 0);

        // Small raster: vertical sync on line 2 only, changing at X = 0
        goto_edge(31);
        check("s_y1_vsync",   s_vsync, 0);
        goto_edge(32);
        check("s_y2_x",       s_x, 0);
        check("s_y2_y",       s_y, 2);
        check("s_y2_vsync",   s_vsync, 1);
        goto_edge(47);
        check("s_y2_end_x",   s_x, 7);
        check("s_y2_end_vs",  s_vsync, 1);
        goto_edge(48);
        check("s_y3_y",       s_y, 3);
        check("s_y3_vsync",   s_vsync, 0);

        // Small raster: frame wrap
        goto_edge(63);
        check("s_last_x",      s_x, 7);
        check("s_last_y",      s_y, 3);
        check("s_last_vblank", s_vblank, 1);
        check("s_last_fs",     s_fs, 0);
        check("s_last_fc",     s_fc, 0);
        goto_edge(64);
        check("s_wrap_x",      s_x, 0);
        check("s_wrap_y",      s_y, 0);
        check("s_wrap_fs",     s_fs, 1);
        check("s_wrap_fc",     s_fc, 1);
        check("s_wrap_vblank", s_vblank, 0);

        n = 0;
        do begin
            goto_edge(edges + 1);
            n++;
        end while (!s_fs && n < 200);
        check("s_frame_period", n, 64);
        check("s_fc_2",         s_fc, 2);

        goto_edge(1040);
        check("f_l1_x",    f_x, 0);
        check("f_l1_y",    f_y, 1);
        check("f_l1_tick", f_tick, 1);

        // Default raster: horizontal blank and sync edges
        goto_edge(1599);
        check("d_x799",        d_x, 799);
        check("d_x799_hblank", d_hblank, 0);
        goto_edge(1600);
        check("d_x800",        d_x, 800);
        check("d_x800_hblank", d_hblank, 1);
        goto_edge(1711);
        check("d_x855_hsync",  d_hsync, 0);
        goto_edge(1712);
        check("d_x856",        d_x, 856);
        check("d_x856_hsync",  d_hsync, 1);
        goto_edge(1895);
        check("f_x855",        f_x, 855);
        check("f_x855_hsync",  f_hsync, 1);
        goto_edge(1896);
        check("f_x856_hsync",  f_hsync, 0);
        goto_edge(1951);
        check("d_x975_hsync",  d_hsync, 1);
        goto_edge(1952);
        check("d_x976",        d_x, 976);
        check("d_x976_hsync",  d_hsync, 0);

        // Default raster: line wrap
        goto_edge(2079);
        check("d_x1039",        d_x, 1039);
        check("d_x1039_y",      d_y, 0);
        check("d_x1039_hblank", d_hblank, 1);
        check("d_x1039_vblank", d_vblank, 0);
        goto_edge(2080);
        check("d_wrap_x",      d_x, 0);
        check("d_wrap_y",      d_y, 1);
        check("d_wrap_tick",   d_tick, 1);
        check("d_wrap_hblank", d_hblank, 0);
        check("f_l2_x",        f_x, 0);
        check("f_l2_y",        f_y, 2);

        n = 0;
        do begin
            goto_edge(edges + 1);
            n++;
        end while (!(d_x == 11'd0 && d_tick) && n < 3000);
        check("d_line_period", n, 2080);
        check("d_l2_y",        d_y, 2);

        n = 0;
        do begin
            goto_edge(edges + 1);
            n++;
        end while (f_x != 11'd0 && n < 2000);
        check("f_line_period", n, 1040);
        check("f_tick_cont",   f_tick, 1);

        // FrameCount wrap after 256 small frames
        goto_edge(16383);
        check("s_fc_255",   s_fc, 255);
        check("s_fc255_x",  s_x, 7);
        check("s_fc255_y",  s_y, 3);
        goto_edge(16384);
        check("s_fc_wrap",  s_fc, 0);
        check("s_fs_wrap",  s_fs, 1);
        goto_edge(16385);
        check("s_fc_hold",  s_fc, 0);
        check("s_fs_clear", s_fs, 0);

        // Asynchronous reset mid-line
        RESET = 1'b1;
        repeat (2) @(negedge CLK_100MHz);
        RESET = 1'b0;
        edges = 0;
        goto_edge(3080);
        check("mid_d_x",      d_x, 500);
        check("mid_d_y",      d_y, 1);
        check("mid_d_tick",   d_tick, 1);
        check("mid_s_fc",     s_fc, 48);
        check("mid_s_hblank", s_hblank, 1);
        check("mid_f_x",      f_x, 1000);
        check("mid_f_y",      f_y, 2);
        #1 RESET = 1'b1;
        #1;
        check("arst_d_x",      d_x, 0);
        check("arst_d_y",      d_y, 0);
        check("arst_d_tick",   d_tick, 0);
        check("arst_s_fc",     s_fc, 0);
        check("arst_s_hblank", s_hblank, 0);
        check("arst_f_x",      f_x, 0);
        check("arst_f_hsync",  f_hsync, 1);

        @(negedge CLK_100MHz);
        RESET = 1'b0;
        edges = 0;
        goto_edge(1);
        check("re_e1_d_x",    d_x, 0);
        check("re_e1_d_tick", d_tick, 0);
        check("re_e1_s_fs",   s_fs, 0);
        goto_edge(2);
        check("re_e2_d_x",    d_x, 1);
        check("re_e2_d_tick", d_tick, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
